// File: rtl/mem_write_checker.sv
// Data-memory store monitor: checks the live store stream against a loaded table of
// expected (address, data) pairs. Define MWC_UNORDERED_EN for any-order matching.
module mem_write_checker #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memwrite,
    input  logic [WIDTH-1:0]             dataadr,
    input  logic [WIDTH-1:0]             writedata,
    input  logic                         ld_valid,
    input  logic [WIDTH-1:0]             ld_adr,
    input  logic [WIDTH-1:0]             ld_data,
    input  logic                         ignore_en,
    input  logic [WIDTH-1:0]             ignore_adr,
    input  logic                         start,
    input  logic                         clear,
    output logic                         busy,
    output logic                         pass,
    output logic                         fail,
    output logic [1:0]                   fail_code,
    output logic [WIDTH-1:0]             fail_adr,
    output logic [WIDTH-1:0]             fail_data,
    output logic                         ld_full,
    output logic [$clog2(DEPTH+1)-1:0]   match_cnt,
    output logic [CNT_W-1:0]             cycle_cnt
);

    localparam int MW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PASS = 2'd2;
    localparam logic [1:0] FAIL = 2'd3;

    localparam logic [1:0] CODE_MISMATCH = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [MW-1:0]    n_q, n_d;
    logic [MW-1:0]    match_q, match_d, match_inc;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             ld_full_q, ld_full_d;
    logic [1:0]       code_q, code_d;
    logic [WIDTH-1:0] fadr_q, fadr_d;
    logic [WIDTH-1:0] fdata_q, fdata_d;

    logic [WIDTH-1:0] tab_adr  [DEPTH];
    logic [WIDTH-1:0] tab_data [DEPTH];

    logic load_en;
    logic store_chk;
    logic hit_ok;

`ifdef MWC_UNORDERED_EN
    logic [DEPTH-1:0] hit_q, hit_d, hit_vec;

    // Lowest-index loaded entry not yet hit that matches this store.
    always_comb begin
        hit_ok  = 1'b0;
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit_ok && (i < int'(n_q)) && !hit_q[i] &&
                tab_adr[i] == dataadr && tab_data[i] == writedata) begin
                hit_ok     = 1'b1;
                hit_vec[i] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        hit_ok = (tab_adr[match_q[IW-1:0]] == dataadr) &&
                 (tab_data[match_q[IW-1:0]] == writedata);
    end
`endif

    assign store_chk = memwrite && !(ignore_en && dataadr == ignore_adr);
    assign match_inc = match_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        match_d   = match_q;
        cyc_d     = cyc_q;
        ld_full_d = ld_full_q;
        code_d    = code_q;
        fadr_d    = fadr_q;
        fdata_d   = fdata_q;
        load_en   = 1'b0;
`ifdef MWC_UNORDERED_EN
        hit_d     = hit_q;
`endif
        if (clear) begin
            state_d   = IDLE;
            n_d       = '0;
            ld_full_d = 1'b0;
            match_d   = '0;
            cyc_d     = '0;
            code_d    = '0;
            fadr_d    = '0;
            fdata_d   = '0;
`ifdef MWC_UNORDERED_EN
            hit_d     = '0;
`endif
        end else if (start && state_q != RUN) begin
            match_d = '0;
            cyc_d   = '0;
            code_d  = '0;
            fadr_d  = '0;
            fdata_d = '0;
            state_d = (n_q == '0) ? PASS : RUN;
`ifdef MWC_UNORDERED_EN
            hit_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_valid) begin
                        if (n_q < MW'(DEPTH)) begin
                            load_en = 1'b1;
                            n_d     = n_q + 1'b1;
                        end else begin
                            ld_full_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    cyc_d = cyc_q + 1'b1;
                    if (store_chk && !hit_ok) begin
                        state_d = FAIL;
                        code_d  = CODE_MISMATCH;
                        fadr_d  = dataadr;
                        fdata_d = writedata;
                    end else begin
                        if (store_chk) begin
                            match_d = match_inc;
`ifdef MWC_UNORDERED_EN
                            hit_d   = hit_q | hit_vec;
`endif
                        end
                        // A completing store in the last budget cycle beats the timeout.
                        if (store_chk && match_inc == n_q) begin
                            state_d = PASS;
                        end else if (cyc_q == CNT_W'(TIMEOUT - 1)) begin
                            state_d = FAIL;
                            code_d  = CODE_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            n_q       <= '0;
            match_q   <= '0;
            cyc_q     <= '0;
            ld_full_q <= 1'b0;
            code_q    <= '0;
            fadr_q    <= '0;
            fdata_q   <= '0;
`ifdef MWC_UNORDERED_EN
            hit_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            match_q   <= match_d;
            cyc_q     <= cyc_d;
            ld_full_q <= ld_full_d;
            code_q    <= code_d;
            fadr_q    <= fadr_d;
            fdata_q   <= fdata_d;
`ifdef MWC_UNORDERED_EN
            hit_q     <= hit_d;
`endif
        end
    end

    // Table contents need no reset: n_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && load_en) begin
            tab_adr[n_q[IW-1:0]]  <= ld_adr;
            tab_data[n_q[IW-1:0]] <= ld_data;
        end
    end

    assign busy      = (state_q == RUN);
    assign pass      = (state_q == PASS);
    assign fail      = (state_q == FAIL);
    assign fail_code = code_q;
    assign fail_adr  = fadr_q;
    assign fail_data = fdata_q;
    assign ld_full   = ld_full_q;
    assign match_cnt = match_q;
    assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_write_checker;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1000;
    localparam int CNT_W   = 16;

    localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;

    logic              clk, reset, memwrite, ld_valid, ignore_en, start, clear;
    logic [WIDTH-1:0]  dataadr, writedata, ld_adr, ld_data, ignore_adr;
    logic              busy, pass, fail, ld_full;
    logic [1:0]        fail_code;
    logic [WIDTH-1:0]  fail_adr, fail_data;
    logic [2:0]        match_cnt;
    logic [CNT_W-1:0]  cycle_cnt;

    int checks = 0;
    int errors = 0;

    mem_write_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .ld_valid(ld_valid), .ld_adr(ld_adr), .ld_data(ld_data),
        .ignore_en(ignore_en), .ignore_adr(ignore_adr), .start(start), .clear(clear),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_adr(fail_adr), .fail_data(fail_data), .ld_full(ld_full),
        .match_cnt(match_cnt), .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected table as queues, verdict as a plain state number.
    bit               m_valid = 0;
    int               m_state;
    logic [WIDTH-1:0] ea[$];
    logic [WIDTH-1:0] ed[$];
    bit               hits[DEPTH];
    int               m_match, m_cyc, m_code, m_found, m_old;
    bit               m_full;
    logic [WIDTH-1:0] m_fadr, m_fdata;

    task automatic model_clear_status();
        m_match = 0; m_cyc = 0; m_code = 0; m_fadr = '0; m_fdata = '0;
        for (int i = 0; i < DEPTH; i++) hits[i] = 0;
    endtask

    always @(posedge clk) begin
        if (reset || clear) begin
            m_valid = 1;
            m_state = M_IDLE;
            ea.delete();
            ed.delete();
            m_full = 0;
            model_clear_status();
        end else if (start && m_state != M_RUN) begin
            model_clear_status();
            m_state = (ea.size() == 0) ? M_PASS : M_RUN;
        end else if (m_state == M_IDLE) begin
            if (ld_valid) begin
                if (ea.size() < DEPTH) begin
                    ea.push_back(ld_adr);
                    ed.push_back(ld_data);
                end else begin
                    m_full = 1;
                end
            end
        end else if (m_state == M_RUN) begin
            m_old = m_cyc;
            m_cyc = m_cyc + 1;
            if (memwrite && !(ignore_en && dataadr == ignore_adr)) begin
                m_found = -1;
`ifdef MWC_UNORDERED_EN
                for (int i = 0; i < ea.size(); i++)
                    if (m_found < 0 && !hits[i] && ea[i] == dataadr && ed[i] == writedata)
                        m_found = i;
`else
                if (ea[m_match] == dataadr && ed[m_match] == writedata) m_found = m_match;
`endif
                if (m_found < 0) begin
                    m_state = M_FAIL; m_code = 1; m_fadr = dataadr; m_fdata = writedata;
                end else begin
                    hits[m_found] = 1;
                    m_match = m_match + 1;
                    if (m_match == ea.size()) m_state = M_PASS;
                    else if (m_old == TIMEOUT - 1) begin m_state = M_FAIL; m_code = 2; end
                end
            end else if (m_old == TIMEOUT - 1) begin
                m_state = M_FAIL; m_code = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, m_state == M_RUN);
            chk("pass", pass, m_state == M_PASS);
            chk("fail", fail, m_state == M_FAIL);
            chk("fail_code", fail_code, m_code);
            chk("fail_adr", fail_adr, m_fadr);
            chk("fail_data", fail_data, m_fdata);
            chk("ld_full", ld_full, m_full);
            chk("match_cnt", match_cnt, m_match);
            chk("cycle_cnt", cycle_cnt, m_cyc);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        ld_valid = 1; ld_adr = a; ld_data = d; cyc(); ld_valid = 0;
    endtask

    task automatic do_store(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        memwrite = 1; dataadr = a; writedata = d; cyc(); memwrite = 0;
    endtask

    task automatic do_start();
        start = 1; cyc(); start = 0;
    endtask

    task automatic do_clear();
        clear = 1; cyc(); clear = 0;
    endtask

    int waited;

    initial begin
        reset = 1; memwrite = 0; ld_valid = 0; start = 0; clear = 0;
        dataadr = '0; writedata = '0; ld_adr = '0; ld_data = '0;
        ignore_en = 1; ignore_adr = 32'h80;
        cyc(); cyc();
        chk("reset_busy", busy, 0);
        chk("reset_cycle_cnt", cycle_cnt, 0);
        reset = 0;

        // Scratch-address stores skipped, then the one expected store passes.
        do_load(32'h84, 32'd9);
        do_start();
        do_store(32'h80, 32'd7);
        do_store(32'h80, 32'd3);
        do_store(32'h84, 32'd9);
        chk("s1_pass", pass, 1);
        chk("s1_fail", fail, 0);
        chk("s1_match", match_cnt, 1);
        chk("s1_cycles", cycle_cnt, 3);
        do_store(32'h88, 32'd1);
        chk("s1_sticky", pass, 1);

        // Data mismatch, then a correct store must not change the verdict.
        do_start();
        do_store(32'h84, 32'd7);
        chk("s2_fail", fail, 1);
        chk("s2_code", fail_code, 2'b01);
        chk("s2_adr", fail_adr, 32'h84);
        chk("s2_data", fail_data, 32'd7);
        do_store(32'h84, 32'd9);
        chk("s2_sticky_fail", fail, 1);
        chk("s2_sticky_data", fail_data, 32'd7);

        // Timeout with no stores.
        do_start();
        waited = 0;
        while (!fail && waited < TIMEOUT + 100) begin
            cyc();
            waited++;
        end
        chk("s3_latency", waited, TIMEOUT);
        chk("s3_code", fail_code, 2'b10);
        chk("s3_cycles", cycle_cnt, TIMEOUT);

        // Completing store in the very last budget cycle wins.
        do_start();
        repeat (TIMEOUT - 1) cyc();
        chk("s3b_cycle_before", cycle_cnt, TIMEOUT - 1);
        do_store(32'h84, 32'd9);
        chk("s3b_pass", pass, 1);
        chk("s3b_code", fail_code, 0);

        // Table overflow, full in-order run, restart.
        do_clear();
        chk("s4_cleared", pass, 0);
        do_load(32'h84, 32'd9);
        do_load(32'h88, 32'd5);
        do_load(32'h8c, 32'd1);
        do_load(32'h90, 32'd2);
        chk("s4_not_full", ld_full, 0);
        do_load(32'h94, 32'd3);
        chk("s4_full", ld_full, 1);
        do_start();
        do_store(32'h84, 32'd9);
        do_store(32'h88, 32'd5);
        do_store(32'h8c, 32'd1);
        chk("s4_midway", busy, 1);
        do_store(32'h90, 32'd2);
        chk("s4_pass", pass, 1);
        chk("s4_match", match_cnt, 4);
        do_start();
        chk("s4_restart_busy", busy, 1);
        chk("s4_restart_match", match_cnt, 0);
        chk("s4_restart_cycles", cycle_cnt, 0);

        // Reset mid-run drops the table.
        do_clear();
        do_load(32'h84, 32'd9);
        do_load(32'h88, 32'd5);
        do_start();
        do_store(32'h84, 32'd9);
        chk("s5_one_match", match_cnt, 1);
        reset = 1; cyc(); reset = 0;
        chk("s5_busy", busy, 0);
        chk("s5_match", match_cnt, 0);
        do_start();
        chk("s5_empty_pass", pass, 1);

        // Out-of-order stores and a repeated store.
        do_clear();
        do_load(32'h84, 32'd9);
        do_load(32'h88, 32'd5);
        do_start();
        do_store(32'h88, 32'd5);
        do_store(32'h84, 32'd9);
`ifdef MWC_UNORDERED_EN
        chk("s6_unordered_pass", pass, 1);
`else
        chk("s6_inorder_fail", fail, 1);
`endif
        do_start();
        do_store(32'h88, 32'd5);
        do_store(32'h88, 32'd5);
        chk("s6_repeat_fail", fail, 1);
        chk("s6_repeat_code", fail_code, 2'b01);
        chk("s6_repeat_adr", fail_adr, 32'h88);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
